clock24_time: RTL and testbench
===============================

# clock24_time

24-hour time-of-day counter for the clock24 design. Consumes the 100 Hz clock enable (CE10) from the clock-enable generator and keeps hours, minutes, seconds and hundredths in packed BCD. A MODE/INC pulse interface lets the user set hours and minutes. The BCD outputs feed the display multiplexer stage.

## Interface
- PRESET_HOUR, 8'h00: BCD hour loaded on reset.
- PRESET_MIN, 8'h00: BCD minute loaded on reset.
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- CE10  in  1  100 Hz clock enable, one CLK cycle wide.
- MODE  in  1  debounced single-cycle pulse; advances the set-state machine.
- INC  in  1  debounced single-cycle pulse; increments the selected field.
- HOUR  out  8  BCD 00–23.
- MIN  out  8  BCD 00–59.
- SEC  out  8  BCD 00–59.
- CS  out  8  BCD hundredths 00–99.
- SETSEL  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 alarm-set (alarm builds only).
- CE_SEC  out  1  one-cycle pulse on the CE10 edge where SEC advances.

## Operation
- Reset: HOUR=PRESET_HOUR, MIN=PRESET_MIN, SEC=00, CS=00, state RUN, SETSEL=00, CE_SEC=0.
- FSM transitions on MODE: RUN→SET_HOUR→SET_MIN→RUN. With alarm: SET_MIN→SET_AHOUR→SET_AMIN→RUN.
- RUN: each CE10 increments CS. Carries ripple in the same cycle:
  - CS 99→00 increments SEC.
  - SEC 59→00 increments MIN.
  - MIN 59→00 increments HOUR.
  - HOUR 23→00 wraps to 00.
- Each digit pair is a BCD counter. The low nibble wraps 9→0 with a carry. The mod limit is checked on the full byte.
- SET states: time is frozen (CE10 ignored). INC increments the selected field mod its limit, with no carry into other fields: 23→00, 59→00.
- Leaving SET_MIN (to RUN or SET_AHOUR): SEC and CS cleared to 00.
- Priority in one cycle: RST > MODE > INC > CE10. INC in the same cycle as MODE is dropped.
- CE_SEC=1 exactly on the CE10 cycle where CS wraps 99→00 in RUN.

## Timing
- All outputs are registered and update on the CLK edge that samples CE10/INC/MODE: one-cycle latency.
- Full carry ripple resolves in a single cycle. 23:59:59.99 + CE10 → 00:00:00.00 on the next edge.
- Reset mid-operation, including mid-SET: the next edge applies reset values, regardless of other inputs.
- CE10 held high for multiple cycles counts once per cycle. This is the caller's responsibility; no edge detect.

## Configuration
- CLOCK24_ALARM_EN defined:
  - Adds AHOUR/AMIN BCD registers, reset 07:00, and output ALARM (1 bit).
  - Adds FSM states SET_AHOUR/SET_AMIN; INC adjusts them mod 24/60.
  - ALARM is registered, high while state=RUN and HOUR==AHOUR and MIN==AMIN, so it lasts the whole minute.
  - ALARM reset value is 0. ALARM is 0 in all SET states.
- CLOCK24_ALARM_EN undefined:
  - No alarm registers, no ALARM port, three-state FSM.
  - SETSEL never equals 11.

## Structure
- Shared package clock24_pkg contains:
  - state enum: ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_SET_AHOUR, ST_SET_AMIN;
  - BCD limit constants: BCD_MAX_HOUR 8'h23, BCD_MAX_MIN 8'h59, BCD_MAX_CS 8'h99;
  - SETSEL encodings.
- One sub-module, bcd_mod_counter, with parameter MAX:
  - two-digit BCD counter with clear, enable and carry-out;
  - instantiated four times for CS/SEC/MIN/HOUR, plus twice more when alarm is enabled.

## Test plan
- Reset with PRESET 12/34 → HOUR=12, MIN=34, SEC=00, CS=00, SETSEL=00 one edge after RST.
- Preload 23:59:59.99 via SET, return to RUN, one CE10 → 00:00:00.00 and CE_SEC=1 for one cycle.
- 100 CE10 pulses from 00:00:00.00 → 00:00:01.00. CS passes 09→10 (BCD carry), never shows 0A.
- MODE once, INC ×25 → HOUR goes 23 then 00 then 01. MIN is unchanged, and the time is frozen despite CE10.
- In SET_MIN at SEC=42, MODE → RUN with SEC=00, CS=00. MODE and INC in the same cycle → state advances, field unchanged.
- CLOCK24_ALARM_EN: set alarm 07:01, run from 07:00:59.99, one CE10 → ALARM=1 next edge. It stays 1 until MIN=02, and RST clears it at once.

Source files
------------

// File: rtl/clock24_pkg.sv
// Shared types and constants for the clock24 time-of-day path: FSM states, BCD limits, SETSEL codes.
// No logic here; latency and backpressure are properties of the modules that import it.
package clock24_pkg;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_SET_HOUR  = 3'd1,
      ST_SET_MIN   = 3'd2,
      ST_SET_AHOUR = 3'd3,
      ST_SET_AMIN  = 3'd4
   } state_t;

   localparam logic [7:0] BCD_MAX_HOUR = 8'h23;
   localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
   localparam logic [7:0] BCD_MAX_CS   = 8'h99;

   localparam logic [1:0] SETSEL_RUN   = 2'b00;
   localparam logic [1:0] SETSEL_HOUR  = 2'b01;
   localparam logic [1:0] SETSEL_MIN   = 2'b10;
   localparam logic [1:0] SETSEL_ALARM = 2'b11;

   function automatic logic [1:0] setsel_of(input state_t st);
      logic [1:0] sel;
      case (st)
         ST_SET_HOUR:  sel = SETSEL_HOUR;
         ST_SET_MIN:   sel = SETSEL_MIN;
         ST_SET_AHOUR: sel = SETSEL_ALARM;
         ST_SET_AMIN:  sel = SETSEL_ALARM;
         default:      sel = SETSEL_RUN;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/clock24_time_bcd_mod_counter.sv
// Two-digit packed-BCD counter wrapping at MAX, with clear, enable and combinational carry-out.
// One-cycle update; no backpressure, counts on every enabled cycle.
module bcd_mod_counter #(
   parameter logic [7:0] MAX  = 8'h99,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       clr,
   input  logic       en,
   output logic [7:0] q,
   output logic [7:0] nxt,
   output logic       co
);

   logic [7:0] inc_val;

   always_comb begin
      inc_val = q;
      if (q == MAX)
         inc_val = 8'h00;
      else if (q[3:0] == 4'h9)
         inc_val = {q[7:4] + 4'h1, 4'h0};
      else
         inc_val = {q[7:4], q[3:0] + 4'h1};

      nxt = q;
      if (clr)
         nxt = 8'h00;
      else if (en)
         nxt = inc_val;
   end

   // carry only on a real wrap; a clear never ripples into the next field
   assign co = en & ~clr & (q == MAX);

   always_ff @(posedge CLK) begin
      if (RST)
         q <= INIT;
      else
         q <= nxt;
   end

endmodule

// File: rtl/clock24_time.sv
// 24-hour BCD time-of-day counter with MODE/INC setting; optional alarm under CLOCK24_ALARM_EN.
// All outputs registered, one-cycle latency; no backpressure, CE10 counted once per enabled cycle.
module clock24_time
   import clock24_pkg::*;
#(
   parameter logic [7:0] PRESET_HOUR = 8'h00,
   parameter logic [7:0] PRESET_MIN  = 8'h00
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE10,
   input  logic       MODE,
   input  logic       INC,
   output logic [7:0] HOUR,
   output logic [7:0] MIN,
   output logic [7:0] SEC,
   output logic [7:0] CS,
   output logic [1:0] SETSEL,
`ifdef CLOCK24_ALARM_EN
   output logic       ALARM,
`endif
   output logic       CE_SEC
);

   state_t     state, state_nxt;
   logic       run, inc_ok, clr_sc;
   logic       cs_en, cs_co, sec_co, min_co, hour_co;
   logic       min_en, hour_en;
   logic [7:0] cs_nxt, sec_nxt, min_nxt, hour_nxt;

   always_comb begin
      state_nxt = state;
      if (MODE) begin
         case (state)
            ST_RUN:      state_nxt = ST_SET_HOUR;
            ST_SET_HOUR: state_nxt = ST_SET_MIN;
`ifdef CLOCK24_ALARM_EN
            ST_SET_MIN:   state_nxt = ST_SET_AHOUR;
            ST_SET_AHOUR: state_nxt = ST_SET_AMIN;
`endif
            default:     state_nxt = ST_RUN;
         endcase
      end
   end

   assign run    = (state == ST_RUN);
   assign inc_ok = INC & ~MODE;
   assign cs_en  = run & CE10 & ~MODE;
   assign clr_sc = MODE & (state == ST_SET_MIN);
   // in SET states the field steps on INC alone; run-mode carries are blocked
   assign min_en  = run ? sec_co : ((state == ST_SET_MIN) & inc_ok);
   assign hour_en = run ? min_co : ((state == ST_SET_HOUR) & inc_ok);

   bcd_mod_counter #(.MAX(BCD_MAX_CS), .INIT(8'h00)) u_cs (
      .CLK(CLK), .RST(RST), .clr(clr_sc), .en(cs_en), .q(CS), .nxt(cs_nxt), .co(cs_co)
   );
   bcd_mod_counter #(.MAX(BCD_MAX_MIN), .INIT(8'h00)) u_sec (
      .CLK(CLK), .RST(RST), .clr(clr_sc), .en(cs_co), .q(SEC), .nxt(sec_nxt), .co(sec_co)
   );
   bcd_mod_counter #(.MAX(BCD_MAX_MIN), .INIT(PRESET_MIN)) u_min (
      .CLK(CLK), .RST(RST), .clr(1'b0), .en(min_en), .q(MIN), .nxt(min_nxt), .co(min_co)
   );
   bcd_mod_counter #(.MAX(BCD_MAX_HOUR), .INIT(PRESET_HOUR)) u_hour (
      .CLK(CLK), .RST(RST), .clr(1'b0), .en(hour_en), .q(HOUR), .nxt(hour_nxt), .co(hour_co)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_RUN;
         SETSEL <= SETSEL_RUN;
         CE_SEC <= 1'b0;
      end else begin
         state  <= state_nxt;
         SETSEL <= setsel_of(state_nxt);
         CE_SEC <= cs_co;
      end
   end

`ifdef CLOCK24_ALARM_EN
   logic [7:0] ahour, amin, ahour_nxt, amin_nxt;
   logic       ahour_co, amin_co;
   logic       unused_alarm;

   bcd_mod_counter #(.MAX(BCD_MAX_HOUR), .INIT(8'h07)) u_ahour (
      .CLK(CLK), .RST(RST), .clr(1'b0), .en((state == ST_SET_AHOUR) & inc_ok),
      .q(ahour), .nxt(ahour_nxt), .co(ahour_co)
   );
   bcd_mod_counter #(.MAX(BCD_MAX_MIN), .INIT(8'h00)) u_amin (
      .CLK(CLK), .RST(RST), .clr(1'b0), .en((state == ST_SET_AMIN) & inc_ok),
      .q(amin), .nxt(amin_nxt), .co(amin_co)
   );

   assign unused_alarm = ^{cs_nxt, sec_nxt, hour_co, ahour_co, amin_co};

   // compare next-state values so ALARM tracks HOUR/MIN on the same edge and drops on entering SET
   always_ff @(posedge CLK) begin
      if (RST)
         ALARM <= 1'b0;
      else
         ALARM <= (state_nxt == ST_RUN) && (hour_nxt == ahour_nxt) && (min_nxt == amin_nxt);
   end
`else
   logic unused_nxt;
   assign unused_nxt = ^{cs_nxt, sec_nxt, min_nxt, hour_nxt, hour_co};
`endif

endmodule

// File: tb/tb_clock24_time.sv
// Bench for clock24_time: directed scenarios plus random MODE/INC/CE10/RST, every cycle checked
// against an arithmetic time-of-day model (integer fields, total-hundredths carry).
module tb_clock24_time;

`ifdef CLOCK24_ALARM_EN
   localparam bit ALARM_EN = 1'b1;
`else
   localparam bit ALARM_EN = 1'b0;
`endif
   localparam int PH = 12;
   localparam int PM = 34;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CE10 = 1'b0;
   logic       MODE = 1'b0;
   logic       INC = 1'b0;
   logic [7:0] HOUR, MIN, SEC, CS;
   logic [1:0] SETSEL;
   logic       CE_SEC;
`ifdef CLOCK24_ALARM_EN
   logic       ALARM;
`endif

   clock24_time #(.PRESET_HOUR(8'h12), .PRESET_MIN(8'h34)) dut (
      .CLK(CLK), .RST(RST), .CE10(CE10), .MODE(MODE), .INC(INC),
      .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .CS(CS), .SETSEL(SETSEL),
`ifdef CLOCK24_ALARM_EN
      .ALARM(ALARM),
`endif
      .CE_SEC(CE_SEC)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // model state: plain integers, st 0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_AHOUR 4=SET_AMIN
   int mh, mm, ms, mc, mst, mah, mam;
   bit mce, malarm;

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r = 8'(((v / 10) << 4) + (v % 10));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_update(input bit r, input bit md, input bit in, input bit ce);
      int t;
      if (r) begin
         mh = PH; mm = PM; ms = 0; mc = 0; mst = 0; mce = 0; mah = 7; mam = 0;
      end else begin
         mce = 0;
         if (md) begin
            if (mst == 2) begin ms = 0; mc = 0; end
            case (mst)
               0: mst = 1;
               1: mst = 2;
               2: mst = ALARM_EN ? 3 : 0;
               3: mst = 4;
               default: mst = 0;
            endcase
         end else if (in && mst != 0) begin
            case (mst)
               1: mh = (mh + 1) % 24;
               2: mm = (mm + 1) % 60;
               3: mah = (mah + 1) % 24;
               default: mam = (mam + 1) % 60;
            endcase
         end else if (ce && mst == 0) begin
            mce = (mc == 99);
            t = (((mh * 60 + mm) * 60 + ms) * 100 + mc + 1) % 8640000;
            mh = t / 360000;
            mm = (t / 6000) % 60;
            ms = (t / 100) % 60;
            mc = t % 100;
         end
      end
      malarm = !r && ALARM_EN && mst == 0 && mh == mah && mm == mam;
   endtask

   task automatic compare_all();
      chk("hour", 32'(HOUR), 32'(bcd(mh)));
      chk("min", 32'(MIN), 32'(bcd(mm)));
      chk("sec", 32'(SEC), 32'(bcd(ms)));
      chk("cs", 32'(CS), 32'(bcd(mc)));
      chk("setsel", 32'(SETSEL), (mst >= 3) ? 32'd3 : 32'(mst));
      chk("ce_sec", 32'(CE_SEC), 32'(mce));
`ifdef CLOCK24_ALARM_EN
      chk("alarm", 32'(ALARM), 32'(malarm));
`endif
   endtask

   task automatic step(input bit r, input bit md, input bit in, input bit ce);
      RST = r; MODE = md; INC = in; CE10 = ce;
      @(posedge CLK);
      model_update(r, md, in, ce);
      #1;
      compare_all();
   endtask

   task automatic repeat_step(input int n, input bit md, input bit in, input bit ce);
      for (int i = 0; i < n; i++) step(1'b0, md, in, ce);
   endtask

   initial begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      // set 23:59, run to 23:59:59.99, then the full-ripple wrap
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat_step(11, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat_step(25, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (ALARM_EN) repeat_step(2, 1'b1, 1'b0, 1'b0);
      repeat_step(5999, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      repeat_step(100, 1'b0, 1'b0, 1'b1);
      // hour set with CE10 present: time frozen, hour walks through 23 -> 00 -> 01
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat_step(25, 1'b0, 1'b1, 1'b1);
      repeat_step(ALARM_EN ? 4 : 2, 1'b1, 1'b0, 1'b0);
      repeat_step(4200, 1'b0, 1'b0, 1'b1);
      repeat_step(2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (ALARM_EN) repeat_step(2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);

`ifdef CLOCK24_ALARM_EN
      // time 07:00, alarm 07:01, run across the alarm minute
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat_step(19, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat_step(26, 1'b0, 1'b1, 1'b0);
      repeat_step(2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat_step(6000, 1'b0, 1'b0, 1'b1);
      repeat_step(3000, 1'b0, 1'b0, 1'b1);
      repeat_step(3000, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
`endif

      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
